// File: rtl/fir_seq.sv
// fir_seq: per-sample command sequencer feeding the sfilt MAC stage.
// Define FIR_SEQ_ROUND_EN to add the shift/round command (cmd 2) to every stream.
module fir_seq #(
  parameter int TAPS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pushin,
  input  logic signed [31:0]      din,
  output logic                    ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [31:0]      coef_wdata,
  input  logic                    shift_we,
  input  logic [6:0]              shift_wdata,
  output logic                    pushout,
  output logic [1:0]              cmd,
  output logic signed [31:0]      q,
  output logic signed [31:0]      h
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_W = (AW+1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, SHIFT, FLUSH} state_t;

  state_t             state, state_nx;
  logic [AW-1:0]      k, k_nx, k_inc;
  logic [AW-1:0]      wptr, wptr_inc, rd_idx;
  logic signed [31:0] dl   [TAPS];
  logic signed [31:0] coef [TAPS];
  logic signed [31:0] coef0_eff;
  logic               coef_ok;
  logic               pushout_nx;
  logic [1:0]         cmd_nx;
  logic signed [31:0] q_nx, h_nx;

`ifdef FIR_SEQ_ROUND_EN
  logic [6:0] shift;
`else
  logic unused_shift;
  assign unused_shift = ^{shift_we, shift_wdata};
`endif

  assign k_inc    = k + 1'b1;
  assign wptr_inc = (wptr == LAST_K) ? '0 : wptr + 1'b1;
  assign coef_ok  = ({1'b0, coef_addr} < TAPS_W);

  // Tap k+1 counted back from the newest sample, wrapping modulo TAPS
  assign rd_idx = (k_inc > wptr) ? AW'({1'b0, wptr} + TAPS_W - {1'b0, k_inc})
                                 : wptr - k_inc;

  // A coefficient written in the accepting cycle must already reach the first command
  assign coef0_eff = (coef_we && coef_addr == '0) ? coef_wdata : coef[0];

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    pushout_nx = 1'b0;
    cmd_nx     = 2'd0;
    q_nx       = '0;
    h_nx       = '0;
    case (state)
      IDLE: begin
        if (pushin) begin
          state_nx   = MAC;
          k_nx       = '0;
          pushout_nx = 1'b1;
          cmd_nx     = 2'd0;
          q_nx       = din;
          h_nx       = coef0_eff;
        end
      end
      MAC: begin
        pushout_nx = 1'b1;
        if (k == LAST_K) begin
`ifdef FIR_SEQ_ROUND_EN
          state_nx = SHIFT;
          cmd_nx   = 2'd2;
          h_nx     = {25'b0, shift};
`else
          state_nx = FLUSH;
          cmd_nx   = 2'd3;
`endif
        end else begin
          k_nx   = k_inc;
          cmd_nx = 2'd1;
          q_nx   = dl[rd_idx];
          h_nx   = coef[k_inc];
        end
      end
`ifdef FIR_SEQ_ROUND_EN
      SHIFT: begin
        state_nx   = FLUSH;
        pushout_nx = 1'b1;
        cmd_nx     = 2'd3;
      end
`endif
      FLUSH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so commands start right after acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      ready   <= 1'b1;
      pushout <= 1'b0;
      cmd     <= 2'd0;
      q       <= '0;
      h       <= '0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      ready   <= (state_nx == IDLE);
      pushout <= pushout_nx;
      cmd     <= cmd_nx;
      q       <= q_nx;
      h       <= h_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dl[i]   <= '0;
        coef[i] <= '0;
      end
`ifdef FIR_SEQ_ROUND_EN
      shift <= '0;
`endif
    end else if (state == IDLE) begin
      if (coef_we && coef_ok)
        coef[coef_addr] <= coef_wdata;
`ifdef FIR_SEQ_ROUND_EN
      if (shift_we)
        shift <= shift_wdata;
`endif
      if (pushin) begin
        dl[wptr_inc] <= din;
        wptr         <= wptr_inc;
      end
    end
  end

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: random stimulus with a scoreboard of expected sfilt command streams.
// Builds for either setting of FIR_SEQ_ROUND_EN.
module tb_fir_seq;

  localparam int TAPS = 5;
  localparam int AW   = $clog2(TAPS);
`ifdef FIR_SEQ_ROUND_EN
  localparam int NCMD = TAPS + 2;
`else
  localparam int NCMD = TAPS + 1;
`endif
  localparam int PERIOD = NCMD + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [31:0] q;
    logic [31:0] h;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              pushin;
  logic signed [31:0] din;
  logic              ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic signed [31:0] coef_wdata;
  logic              shift_we;
  logic [6:0]        shift_wdata;
  logic              pushout;
  logic [1:0]        cmd;
  logic signed [31:0] q;
  logic signed [31:0] h;

  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          next_ok = 0;
  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] hist[$];
  logic [31:0] mcoef [TAPS];
  logic [6:0]  mshift;

  fir_seq #(.TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .din(din), .ready(ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .shift_we(shift_we), .shift_wdata(shift_wdata),
    .pushout(pushout), .cmd(cmd), .q(q), .h(h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (cyc != e.cyc || cmd !== e.cmd || q !== e.q || h !== e.h) begin
      fails++;
      $display("[TB] FAIL %s: got cyc=%0d cmd=%0d q=%0h h=%0h, expected cyc=%0d cmd=%0d q=%0h h=%0h",
               name, cyc, cmd, q, h, e.cyc, e.cmd, e.q, e.h);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model to the edge they hit
  task automatic applyStimulus(input logic rstv, input logic push, input logic [31:0] d,
                               input logic cwe, input logic [AW-1:0] caddr,
                               input logic [31:0] cdata, input logic swe,
                               input logic [6:0] sdata);
    int   e_edge;
    logic exp_ready;
    exp_t e;
    @(posedge clk);
    #1;
    e_edge    = cyc + 1;
    exp_ready = (e_edge >= next_ok);
    checks++;
    if (ready !== exp_ready) begin
      fails++;
      $display("[TB] FAIL ready cyc=%0d: got %b, expected %b", cyc, ready, exp_ready);
    end
    rst         = rstv;
    pushin      = push;
    din         = d;
    coef_we     = cwe;
    coef_addr   = caddr;
    coef_wdata  = cdata;
    shift_we    = swe;
    shift_wdata = sdata;
    if (!rstv) begin
      while (expq.size() > 0 && expq[$].cyc >= e_edge) void'(expq.pop_back());
      for (int i = 0; i < TAPS; i++) mcoef[i] = '0;
      mshift = '0;
      hist.delete();
      next_ok = e_edge + 1;
    end else if (exp_ready) begin
      if (cwe && int'(caddr) < TAPS) mcoef[int'(caddr)] = cdata;
      if (swe) mshift = sdata;
      if (push) begin
        hist.push_front(d);
        if (hist.size() > TAPS) void'(hist.pop_back());
        for (int k = 0; k < TAPS; k++) begin
          e.cyc = e_edge + k;
          e.cmd = (k == 0) ? 2'd0 : 2'd1;
          e.q   = (k < hist.size()) ? hist[k] : 32'd0;
          e.h   = mcoef[k];
          expq.push_back(e);
        end
`ifdef FIR_SEQ_ROUND_EN
        e.cyc = e_edge + TAPS;
        e.cmd = 2'd2;
        e.q   = '0;
        e.h   = {25'b0, mshift};
        expq.push_back(e);
`endif
        e.cyc = e_edge + NCMD - 1;
        e.cmd = 2'd3;
        e.q   = '0;
        e.h   = '0;
        expq.push_back(e);
        next_ok = e_edge + PERIOD;
      end
    end
  endtask

  // Monitor: every presented command must match the head of the scoreboard
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (pushout === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_cmd cyc=%0d: got cmd=%0d q=%0h h=%0h, expected no command",
                   cyc, cmd, q, h);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("cmd_stream", mon_e);
        end
      end else begin
        checks++;
        if (pushout !== 1'b0 || cmd !== 2'd0 || q !== 32'd0 || h !== 32'd0) begin
          fails++;
          $display("[TB] FAIL idle_outputs cyc=%0d: got pushout=%b cmd=%0d q=%0h h=%0h, expected all 0",
                   cyc, pushout, cmd, q, h);
        end
        if (expq.size() > 0 && expq[0].cyc <= cyc) begin
          checks++;
          fails++;
          mon_e = expq.pop_front();
          $display("[TB] FAIL missing_cmd cyc=%0d: got pushout=0, expected cmd=%0d q=%0h h=%0h at cyc=%0d",
                   cyc, mon_e.cmd, mon_e.q, mon_e.h, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; pushin = 1'b0; din = '0; coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; shift_we = 1'b0; shift_wdata = '0;
    for (int i = 0; i < TAPS; i++) mcoef[i] = '0;
    mshift = '0;

    repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) applyStimulus(1, 0, 0, 1, AW'(i), i + 1, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 1, 7'd3);

    applyStimulus(1, 1, 32'd10, 0, '0, 0, 0, 0);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 1, 32'd20, 0, '0, 0, 0, 0);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);

    // pushin held high across whole sequences
    repeat (2 * PERIOD + 1) applyStimulus(1, 1, $urandom, 0, '0, 0, 0, 0);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);

    // coefficient and shift writes while busy must not land
    applyStimulus(1, 1, 32'd7, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, '0, 100, 1, 7'd9);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);

    // write and push together, then an out-of-range write
    applyStimulus(1, 1, 32'd5, 1, '0, 77, 0, 0);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, AW'(TAPS + 1), 999, 0, 0);
    applyStimulus(1, 1, 32'hFFFF_FFF0, 0, '0, 0, 0, 0);
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);

    repeat (400)
      applyStimulus($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 4) == 0, AW'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 7) == 0, 7'($urandom));

    // reset in the middle of a MAC run
    repeat (PERIOD) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 1, 32'd33, 0, '0, 0, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, '0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 1, 32'd9, 0, '0, 0, 0, 0);

    for (int i = 0; i < 50 && expq.size() > 0; i++)
      applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d commands outstanding, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
